// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage plus EX/MEM pipeline register.
//
// Selects the ALU operands from the ID/EX outputs, evaluates the ALU and
// registers the result with the MEM-stage control bits, destination and
// store data on every clock.
//
// Optional feature, macro EX_MUL_EN: a 32-cycle shift-and-add multiplier
// for aluc 1011. While it runs, ex_stall holds the upstream stages and the
// MEM register latches bubbles. Without the macro, aluc 1011 is a
// single-cycle op that yields 0 and ex_stall is tied low.
//
// Ports:
//   clk                      pipeline clock, all state updates on posedge
//   clrn                     synchronous active-low reset
//   EXwreg/EXm2reg/EXwmem    control bits from ID/EX
//   EXshift                  1: operand A = zero-extended EXimmeOrSa[4:0]
//   EXaluimm                 1: operand B = EXimmeOrSa
//   EXaluc [3:0]             ALU operation code
//   EXwn   [4:0]             destination register number
//   EXqa/EXqb/EXimmeOrSa     32-bit register operands and immediate/shamt
//   MEMwreg/MEMm2reg/MEMwmem registered control bits
//   MEMwn  [4:0]             registered destination
//   MEMalu [31:0]            registered ALU or multiplier result
//   MEMqb  [31:0]            registered store data
//   ex_stall                 combinational, 1 = upstream must hold

module ex_mem_stage (
    input  logic        clk,
    input  logic        clrn,
    input  logic        EXwreg,
    input  logic        EXm2reg,
    input  logic        EXwmem,
    input  logic        EXshift,
    input  logic        EXaluimm,
    input  logic [3:0]  EXaluc,
    input  logic [4:0]  EXwn,
    input  logic [31:0] EXqa,
    input  logic [31:0] EXqb,
    input  logic [31:0] EXimmeOrSa,
    output logic        MEMwreg,
    output logic        MEMm2reg,
    output logic        MEMwmem,
    output logic [4:0]  MEMwn,
    output logic [31:0] MEMalu,
    output logic [31:0] MEMqb,
    output logic        ex_stall
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    // ------------------------------------------------------------------
    // Operand selection and ALU
    // ------------------------------------------------------------------
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_res;

    // Operand muxes; shift amount is zero-extended from the immediate.
    always_comb begin : operand_sel
        alu_a = EXshift  ? {{(XLEN-RW){1'b0}}, EXimmeOrSa[RW-1:0]} : EXqa;
        alu_b = EXaluimm ? EXimmeOrSa : EXqb;
    end

    // Bit 3 only distinguishes the shift/mul group; elsewhere it is ignored.
    always_comb begin : alu
        alu_res = '0;
        casez (EXaluc)
            4'b?000: alu_res = alu_a + alu_b;
            4'b?100: alu_res = alu_a - alu_b;
            4'b?001: alu_res = alu_a & alu_b;
            4'b?101: alu_res = alu_a | alu_b;
            4'b?010: alu_res = alu_a ^ alu_b;
            4'b?110: alu_res = {alu_b[15:0], 16'h0000};
            4'b0011: alu_res = alu_b << alu_a[RW-1:0];
            4'b0111: alu_res = alu_b >> alu_a[RW-1:0];
            4'b1111: alu_res = $signed(alu_b) >>> alu_a[RW-1:0];
            default: alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // EX/MEM pipeline register
    // ------------------------------------------------------------------
    logic            mem_wreg_q,  mem_wreg_d;
    logic            mem_m2reg_q, mem_m2reg_d;
    logic            mem_wmem_q,  mem_wmem_d;
    logic [RW-1:0]   mem_wn_q,    mem_wn_d;
    logic [XLEN-1:0] mem_alu_q,   mem_alu_d;
    logic [XLEN-1:0] mem_qb_q,    mem_qb_d;

`ifdef EX_MUL_EN
    // ------------------------------------------------------------------
    // Iterative multiplier: IDLE detect, 32 RUN steps, DONE writeback
    // ------------------------------------------------------------------
    localparam logic [3:0]    ALUC_MUL = 4'b1011;
    localparam logic [RW-1:0] CNT_LAST = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            is_mul;
    logic            mul_load;
    logic            mul_step;
    logic            mem_bubble;
    logic            mem_use_acc;
    logic [XLEN-1:0] mcand_q,  mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] acc_q,    acc_d;
    logic [RW-1:0]   cnt_q,    cnt_d;

    assign is_mul = (EXaluc == ALUC_MUL);

    // State register.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; DONE always returns to IDLE so a held 1011 cannot retrigger.
    always_comb begin : mul_next
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (is_mul) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; stall is masked by clrn so it reads 0 during reset.
    always_comb begin : mul_out
        mul_load    = 1'b0;
        mul_step    = 1'b0;
        mem_bubble  = 1'b0;
        mem_use_acc = 1'b0;
        ex_stall    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_mul) begin
                    mul_load   = 1'b1;
                    mem_bubble = 1'b1;
                    ex_stall   = clrn;
                end
            end
            ST_RUN: begin
                mul_step   = 1'b1;
                mem_bubble = 1'b1;
                ex_stall   = clrn;
            end
            ST_DONE: mem_use_acc = 1'b1;
            default: ;
        endcase
    end

    // Shift-and-add datapath: one partial product per RUN cycle.
    always_comb begin : mul_dp
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (mul_load) begin
            mcand_d  = alu_a;
            mplier_d = alu_b;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (mul_step) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
        end
    end

    // Multiplier registers.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    assign ex_stall = 1'b0;
`endif

    // Next MEM contents: EX values, replaced by a bubble or the product.
    always_comb begin : mem_next
        mem_wreg_d  = EXwreg;
        mem_m2reg_d = EXm2reg;
        mem_wmem_d  = EXwmem;
        mem_wn_d    = EXwn;
        mem_alu_d   = alu_res;
        mem_qb_d    = EXqb;
`ifdef EX_MUL_EN
        if (mem_bubble) begin
            mem_wreg_d  = 1'b0;
            mem_m2reg_d = 1'b0;
            mem_wmem_d  = 1'b0;
            mem_wn_d    = '0;
            mem_alu_d   = '0;
            mem_qb_d    = '0;
        end else if (mem_use_acc) begin
            mem_alu_d   = acc_q;
        end
`endif
    end

    // EX/MEM register.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            mem_wreg_q  <= 1'b0;
            mem_m2reg_q <= 1'b0;
            mem_wmem_q  <= 1'b0;
            mem_wn_q    <= '0;
            mem_alu_q   <= '0;
            mem_qb_q    <= '0;
        end else begin
            mem_wreg_q  <= mem_wreg_d;
            mem_m2reg_q <= mem_m2reg_d;
            mem_wmem_q  <= mem_wmem_d;
            mem_wn_q    <= mem_wn_d;
            mem_alu_q   <= mem_alu_d;
            mem_qb_q    <= mem_qb_d;
        end
    end

    assign MEMwreg  = mem_wreg_q;
    assign MEMm2reg = mem_m2reg_q;
    assign MEMwmem  = mem_wmem_q;
    assign MEMwn    = mem_wn_q;
    assign MEMalu   = mem_alu_q;
    assign MEMqb    = mem_qb_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: scoreboard of expected MEM contents and
// ex_stall per cycle, filled by the stimulus from a behavioural model and
// drained by an independent monitor.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        clrn;
    logic        EXwreg, EXm2reg, EXwmem, EXshift, EXaluimm;
    logic [3:0]  EXaluc;
    logic [4:0]  EXwn;
    logic [31:0] EXqa, EXqb, EXimmeOrSa;
    logic        MEMwreg, MEMm2reg, MEMwmem;
    logic [4:0]  MEMwn;
    logic [31:0] MEMalu, MEMqb;
    logic        ex_stall;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk        (clk),
        .clrn       (clrn),
        .EXwreg     (EXwreg),
        .EXm2reg    (EXm2reg),
        .EXwmem     (EXwmem),
        .EXshift    (EXshift),
        .EXaluimm   (EXaluimm),
        .EXaluc     (EXaluc),
        .EXwn       (EXwn),
        .EXqa       (EXqa),
        .EXqb       (EXqb),
        .EXimmeOrSa (EXimmeOrSa),
        .MEMwreg    (MEMwreg),
        .MEMm2reg   (MEMm2reg),
        .MEMwmem    (MEMwmem),
        .MEMwn      (MEMwn),
        .MEMalu     (MEMalu),
        .MEMqb      (MEMqb),
        .ex_stall   (ex_stall)
    );

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [4:0]  wn;
        logic [31:0] alu;
        logic [31:0] qb;
    } mem_t;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic        shift;
        logic        aluimm;
        logic [3:0]  aluc;
        logic [4:0]  wn;
        logic [31:0] qa;
        logic [31:0] qb;
        logic [31:0] imm;
    } op_t;

    mem_t exp_mem_q[$];
    int   exp_tag_q[$];
    logic exp_stall_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU written from the opcode table with plain arithmetic.
    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [4:0]  s;
        logic [31:0] ones;
        s    = a[4:0];
        ones = 32'hFFFF_FFFF;
        if (c[2:0] == 3'b000) return a + b;
        if (c[2:0] == 3'b100) return a - b;
        if (c[2:0] == 3'b001) return a & b;
        if (c[2:0] == 3'b101) return a | b;
        if (c[2:0] == 3'b010) return a ^ b;
        if (c[2:0] == 3'b110) return b * 32'h0001_0000;
        if (c == 4'b0011) return b << s;
        if (c == 4'b0111) return b >> s;
        if (c == 4'b1111) return (b >> s) | (b[31] ? ~(ones >> s) : 32'h0);
`ifdef EX_MUL_EN
        if (c == 4'b1011) return a * b;
`endif
        return 32'h0;
    endfunction

    function automatic op_t mk(input logic [3:0] c, input logic [31:0] qa, input logic [31:0] qb,
                               input logic [31:0] imm, input logic sh, input logic ai,
                               input logic wr, input logic m2, input logic wm,
                               input logic [4:0] wn);
        op_t o;
        o.aluc = c; o.qa = qa; o.qb = qb; o.imm = imm; o.shift = sh; o.aluimm = ai;
        o.wreg = wr; o.m2reg = m2; o.wmem = wm; o.wn = wn;
        return o;
    endfunction

    // Drive one cycle of inputs and record what must follow.
    task automatic drive(input logic rst_v, input op_t o, input mem_t e, input logic s);
        clrn       = rst_v;
        EXwreg     = o.wreg;
        EXm2reg    = o.m2reg;
        EXwmem     = o.wmem;
        EXshift    = o.shift;
        EXaluimm   = o.aluimm;
        EXaluc     = o.aluc;
        EXwn       = o.wn;
        EXqa       = o.qa;
        EXqb       = o.qb;
        EXimmeOrSa = o.imm;
        exp_mem_q.push_back(e);
        exp_tag_q.push_back(cyc);
        exp_stall_q.push_back(s);
        @(posedge clk);
        #1;
    endtask

    function automatic mem_t expect_of(input op_t o);
        mem_t        r;
        logic [31:0] a, b;
        a = o.shift  ? {27'd0, o.imm[4:0]} : o.qa;
        b = o.aluimm ? o.imm : o.qb;
        r.wreg = o.wreg; r.m2reg = o.m2reg; r.wmem = o.wmem;
        r.wn = o.wn; r.alu = ref_alu(o.aluc, a, b); r.qb = o.qb;
        return r;
    endfunction

    // Issue one op; a multiply is held for its whole stall window.
    task automatic issue(input op_t o);
`ifdef EX_MUL_EN
        if (o.aluc == 4'b1011) begin
            for (int i = 0; i < 33; i++) drive(1'b1, o, '0, 1'b1);
            drive(1'b1, o, expect_of(o), 1'b0);
        end else begin
            drive(1'b1, o, expect_of(o), 1'b0);
        end
`else
        drive(1'b1, o, expect_of(o), 1'b0);
`endif
    endtask

    // Start a multiply and reset it while RUN has cnt==10.
    task automatic mul_abort(input op_t o);
`ifdef EX_MUL_EN
        for (int i = 0; i < 11; i++) drive(1'b1, o, '0, 1'b1);
`endif
        drive(1'b0, o, '0, 1'b0);
    endtask

    function automatic op_t rnd_op();
        op_t o;
        o.aluc   = 4'($urandom_range(0, 15));
        o.qa     = $urandom();
        o.qb     = $urandom();
        o.imm    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : $urandom();
        o.shift  = ($urandom_range(0, 3) == 0);
        o.aluimm = $urandom_range(0, 1) == 1;
        o.wreg   = $urandom_range(0, 1) == 1;
        o.m2reg  = $urandom_range(0, 1) == 1;
        o.wmem   = $urandom_range(0, 1) == 1;
        o.wn     = 5'($urandom_range(0, 31));
        return o;
    endfunction

    // Monitor: MEM contents just after each edge, ex_stall mid-cycle.
    initial begin
        mem_t e, got;
        logic s;
        forever begin
            @(posedge clk);
            #3;
            if (exp_mem_q.size() > 0 && exp_tag_q[0] < cyc) begin
                e = exp_mem_q.pop_front();
                void'(exp_tag_q.pop_front());
                got = {MEMwreg, MEMm2reg, MEMwmem, MEMwn, MEMalu, MEMqb};
                n_cmp++;
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL mem @cyc %0d: got wreg=%b m2reg=%b wmem=%b wn=%0d alu=%h qb=%h, want wreg=%b m2reg=%b wmem=%b wn=%0d alu=%h qb=%h",
                             cyc, got.wreg, got.m2reg, got.wmem, got.wn, got.alu, got.qb,
                             e.wreg, e.m2reg, e.wmem, e.wn, e.alu, e.qb);
                end
            end
            @(negedge clk);
            if (exp_stall_q.size() > 0) begin
                s = exp_stall_q.pop_front();
                n_cmp++;
                if (ex_stall !== s) begin
                    n_bad++;
                    $display("FAIL ex_stall @cyc %0d: got %b want %b", cyc, ex_stall, s);
                end
            end
        end
    end

    initial begin
        op_t o;
        clrn = 1'b0; EXwreg = 1'b0; EXm2reg = 1'b0; EXwmem = 1'b0; EXshift = 1'b0;
        EXaluimm = 1'b0; EXaluc = 4'h0; EXwn = 5'd0; EXqa = '0; EXqb = '0; EXimmeOrSa = '0;
        @(posedge clk);
        #1;

        // Reset with busy inputs.
        o = mk(4'b0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9);
        drive(1'b0, o, '0, 1'b0);
        o.aluc = 4'b1011;
        drive(1'b0, o, '0, 1'b0);

        // Directed ALU cases.
        issue(mk(4'b0000, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3));
        issue(mk(4'b0100, 32'd3, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4));
        issue(mk(4'b0000, 32'd0, 32'hDEAD_BEEF, 32'd16, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0));
        issue(mk(4'b1111, 32'd0, 32'h8000_0000, 32'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5));
        issue(mk(4'b0111, 32'd0, 32'h8000_0000, 32'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd6));
        issue(mk(4'b0011, 32'd0, 32'd1, 32'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7));
        issue(mk(4'b0110, 32'd0, 32'd0, 32'h0000_1234, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8));
        issue(mk(4'b1111, 32'd0, 32'h8765_4321, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd10));
        issue(mk(4'b1111, 32'd0, 32'h8000_0000, 32'd31, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd11));
        issue(mk(4'b1001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd12));

        // Multiplies, back to back, then an abort mid-run.
        issue(mk(4'b1011, 32'd7, 32'd6, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd13));
        issue(mk(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd14));
        mul_abort(mk(4'b1011, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd15));
        issue(mk(4'b0000, 32'd100, 32'd23, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd16));

        // Random ops.
        for (int i = 0; i < 300; i++) issue(rnd_op());

        drive(1'b1, mk(4'b0000, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0),
              mk_exp_idle(), 1'b0);
        repeat (2) @(posedge clk);
        #4;
        if (exp_mem_q.size() != 0 || exp_stall_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d mem / %0d stall expectations left, want 0",
                     exp_mem_q.size(), exp_stall_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    function automatic mem_t mk_exp_idle();
        mem_t r;
        r = '0;
        r.alu = 32'd2;
        r.qb  = 32'd1;
        return r;
    endfunction

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute stage plus EX/MEM pipeline register of the 5-stage CPU. Consumes the ID/EX register outputs, selects ALU operands, computes the ALU result and registers it, with the MEM-stage control bits and store data, on each clock. Under `EX_MUL_EN`, adds a 32-cycle iterative multiplier. The multiplier stalls the front end and sends bubbles to MEM while it runs.

## Interface
Parameters: none.
- clk  in  1  pipeline clock; all state updates on posedge
- clrn  in  1  synchronous, active-low reset, sampled on posedge clk
- EXwreg, EXm2reg, EXwmem  in  1 each  control bits from ID/EX
- EXshift  in  1  1: operand A = {27'b0, EXimmeOrSa[4:0]}; 0: A = EXqa
- EXaluimm  in  1  1: operand B = EXimmeOrSa; 0: B = EXqb
- EXaluc  in  4  ALU operation code
- EXwn  in  5  destination register number
- EXqa, EXqb, EXimmeOrSa  in  32 each  register operands and immediate/shift amount
- MEMwreg, MEMm2reg, MEMwmem  out  1 each  registered control bits
- MEMwn  out  5  registered destination
- MEMalu  out  32  registered ALU/multiplier result
- MEMqb  out  32  registered store data (EXqb)
- ex_stall  out  1  combinational; 1 = upstream (PC, IF/ID, ID/EX) must hold

## Operation
- ALU codes. "x" means either value:
  - add x000
  - sub x100
  - and x001
  - or x101
  - xor x010
  - lui x110: B << 16
  - sll 0011: B << A[4:0]
  - srl 0111: logical B >> A[4:0]
  - sra 1111: arithmetic B >>> A[4:0]
  - mul 1011: low 32 bits of A*B, with `EX_MUL_EN` only
- All arithmetic is 32-bit modulo, with no overflow flag.
- Multiplier FSM states:
  - IDLE: if EXaluc==1011, load mcand=A, mplier=B, acc=0, cnt=0, and go to RUN. The MEM stage latches a bubble: MEMwreg=0, MEMwmem=0, MEMm2reg=0, other MEM outputs 0.
  - RUN: each cycle, if mplier[0] then acc += mcand; then mcand <<= 1, mplier >>= 1, cnt++. When cnt==31, the 32nd add is done and the FSM goes to DONE. MEM latches a bubble every RUN cycle.
  - DONE: MEM latches MEMalu=acc plus the current EX control, EXwn and EXqb, which upstream has held stable. The FSM goes to IDLE unconditionally and never re-triggers on the still-present 1011.
- ex_stall = clrn & ((state==IDLE & EXaluc==1011) | state==RUN).
- Non-mul ops in IDLE: MEM registers capture the ALU result and EX inputs every cycle.

## Timing
- Reset value of every output after a posedge clk with clrn=0:
  - MEMwreg=0, MEMm2reg=0, MEMwmem=0, MEMwn=0, MEMalu=0, MEMqb=0
  - state=IDLE, acc=0, cnt=0
  - ex_stall=0 while clrn=0
- Single-cycle ops: 1-cycle latency, from EX inputs to MEM outputs at the next edge. One op is accepted per cycle.
- mul: ex_stall is high for exactly 33 cycles, covering the IDLE detect cycle and 32 RUN cycles.
  - The result appears on MEMalu after the DONE edge, 34 edges after the op first presents.
  - 33 bubbles precede the result.
- Reset mid-RUN: the multiply is aborted, with no writeback and no partial result. The next cycle is IDLE.
- Back-to-back muls: after DONE, the next 1011 from upstream starts a fresh IDLE→RUN sequence.
- A shift amount of 0 passes B unchanged. sra by 31 yields all sign bits.

## Configuration
- Macro `EX_MUL_EN`.
- Defined: the multiplier FSM, datapath and ex_stall logic are compiled in.
- Undefined: the FSM is removed and ex_stall is tied to 0. aluc 1011 is single-cycle and produces MEMalu=0 with control passed through unchanged.

## Test plan
- Reset: clrn=0 for 2 cycles with nonzero inputs -> all MEM outputs 0 and ex_stall=0. Release, then add qa=5, qb=7, aluimm=0 -> MEMalu=12, MEMwreg copied, one cycle later.
- Immediate/sub: aluc=0100, qa=3, aluimm=1, imm=0xFFFFFFFF -> MEMalu=4. Store path: wmem=1, qb=0xDEADBEEF -> MEMqb=0xDEADBEEF, MEMwmem=1.
- Shifts: shift=1, imm[4:0]=4, qb=0x80000000:
  - sra -> 0xF8000000
  - srl -> 0x08000000
  - sll with qb=1 -> 0x10
  - lui with aluimm=1, imm=0x1234 -> 0x12340000
- mul (`EX_MUL_EN`): qa=7, qb=6, aluc=1011, inputs held while stalled:
  - ex_stall high for exactly 33 cycles, during which MEMwreg=0.
  - Then MEMalu=42 and MEMwreg=1.
  - Repeat with 0xFFFFFFFF*0xFFFFFFFF -> 1.
- Reset mid-mul: assert clrn=0 at RUN cnt=10 -> no MEMwreg=1 pulse, ex_stall=0, then a new add completes normally.
- Without `EX_MUL_EN`: aluc=1011 -> ex_stall never rises and MEMalu=0 after 1 cycle.
